// File: rtl/if_prefetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_prefetch
//
// Instruction-fetch stage in front of the control unit / decoder. Holds the
// fetch PC, issues word fetches to instruction memory (at most one request in
// flight), buffers returned words in a small FIFO, and presents the head
// instruction split into op/f3/f7. A redirect from control (pcSrc/pcTarget)
// reloads the fetch PC and flushes everything fetched on the old path.
//
// Handshakes:
//   imem request   : a request is transferred on a rising edge where
//                    imem_req & imem_ready are both high. imem_req never
//                    depends on imem_ready.
//   imem response  : imem_rvalid is a one-cycle strobe carrying imem_rdata for
//                    the single outstanding request; there is no back-pressure.
//   instr output   : the head entry is consumed on a rising edge where
//                    instr_valid & instr_ready are both high. instr_valid never
//                    depends on instr_ready.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     instruction FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_req/imem_addr          fetch request and word address
//   imem_ready                  memory accepts the request
//   imem_rvalid/imem_rdata      fetch response
//   pcSrc/pcTarget              redirect request and target from control
//   instr_ready                 downstream consumes the head instruction
//   instr_valid/instr/pc        head instruction and its address
//   pcPlus4                     pc + 4 (mod 2^32)
//   op/f3/f7                    instr[6:0], instr[14:12], instr[31:25]
//   misaligned                  sticky misaligned-redirect fault
//   dbgState                    fetch FSM state: 0 = RUN, 1 = WAIT, 2 = DROP
//
// Build option:
//   IF_MISALIGN_TRAP_EN  when defined, a redirect to a target with non-zero
//                        low bits sets the sticky misaligned flag and halts
//                        fetching until reset. When undefined, the low two
//                        target bits are cleared and misaligned is tied 0.
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [6:0]  op,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic        misaligned,
  output logic [1:0]  dbgState
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // nothing in flight, may issue
    ST_WAIT = 2'd1,  // one live request in flight
    ST_DROP = 2'd2   // one stale request in flight, its data is thrown away
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [31:0]     fetchPc;
  logic [31:0]     tagPc;       // address of the request currently in flight
  logic [31:0]     targetPc;
  logic            halted;

  logic [31:0]     instrMem [DEPTH];
  logic [31:0]     pcMem    [DEPTH];
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            push;
  logic            pop;

  // ---------------------------------------------------------------------------
  // Redirect target handling and the optional misalignment trap
  // ---------------------------------------------------------------------------
`ifdef IF_MISALIGN_TRAP_EN
  // The trap flag doubles as the halt: once set, nothing is fetched again and
  // the FIFO, flushed by the same redirect, can never refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (pcSrc && (pcTarget[1:0] != 2'b00)) begin
      halted <= 1'b1;
    end
  end

  assign targetPc   = pcTarget;
  assign misaligned = halted;
`else
  assign halted     = 1'b0;
  assign targetPc   = pcTarget & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Fetch FSM, next state and request
  // ---------------------------------------------------------------------------
  // The request only looks at the registered count: the free slot it sees is
  // reserved for the response of this one request, and pops only ever free
  // more space, so a push can never find the FIFO full.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    push      = 1'b0;
    imem_req  = rst_n && (state == ST_RUN) && (count < CW'(DEPTH)) &&
                !pcSrc && !halted;

    case (state)
      ST_RUN: begin
        // A response strobe here has no request behind it and is ignored.
        if (imem_req && imem_ready) begin
          accept    = 1'b1;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pcSrc) begin
          // Data returning in the redirect cycle is already stale; otherwise
          // remember that the pending response must be swallowed.
          stateNext = imem_rvalid ? ST_RUN : ST_DROP;
        end else if (imem_rvalid) begin
          push      = 1'b1;
          stateNext = ST_RUN;
        end
      end
      ST_DROP: begin
        // A further redirect only moves the target; the stale response still
        // has to drain before a new request may go out.
        if (imem_rvalid) begin
          stateNext = ST_RUN;
        end
      end
      default: begin
        stateNext = ST_RUN;
      end
    endcase
  end

  // A redirect flushes the FIFO, so a pop in the same cycle does not matter.
  assign pop = instr_valid && instr_ready && !pcSrc;

  // ---------------------------------------------------------------------------
  // State, PC and FIFO control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      fetchPc <= RESET_PC;
      tagPc   <= RESET_PC;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
    end else begin
      state <= stateNext;

      if (pcSrc) begin
        fetchPc <= targetPc;
      end else if (accept) begin
        fetchPc <= fetchPc + 32'd4;
      end

      if (accept) begin
        tagPc <= fetchPc;
      end

      if (pcSrc) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          wrPtr <= wrPtr + PW'(1);
        end
        if (pop) begin
          rdPtr <= rdPtr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= tagPc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr   = fetchPc;
  assign instr_valid = (count != '0);
  assign instr       = instrMem[rdPtr];
  assign pc          = pcMem[rdPtr];
  assign pcPlus4     = pc + 32'd4;
  assign op          = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign dbgState    = state;

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_if_prefetch
//
// Drives if_prefetch with a randomized instruction memory and randomized
// redirect/drain behaviour. The reference model tracks the program-order
// fetch address, the single memory transaction in flight (live or stale) and
// the queue of instructions that should be waiting downstream. A separate
// monitor pops that queue whenever the DUT hands over an instruction.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        pcSrc = 1'b0;
  logic [31:0] pcTarget = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        misaligned;
  logic [1:0]  dbgState;

  always #5 clk = ~clk;

  if_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pcSrc      (pcSrc),
    .pcTarget   (pcTarget),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .misaligned (misaligned),
    .dbgState   (dbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model state
  // ---------------------------------------------------------------------------
  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] exp_q[$];        // {instr, pc} expected downstream, in order
  logic [31:0] acceptLog[$];    // addresses the DUT had accepted by memory

  logic [31:0] modelPc;         // next program-order fetch address
  logic        modelHalted;
  logic        memBusy;         // a request is in flight at the memory
  logic        memStale;        // ... and its data must be discarded
  logic [31:0] memAddr;
  int          memDelay;

  // stimulus knobs
  int          rdyPct   = 100;
  int          drainPct = 100;
  int          minDelay = 0;
  int          maxDelay = 0;
  int          redirPm  = 0;    // per-mille chance of a random redirect
  logic        forceRedir = 1'b0;
  logic        forceDrain = 1'b0;
  logic [31:0] forceTgt = 32'h0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == RESET_PC) return 32'h40B5_0533;   // sub a0, a0, a1
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return 32'hFFFF_FFF8;           // exercises PC wrap
    t = 32'h0000_2000 + ($urandom_range(0, 255) << 2);
`ifndef IF_MISALIGN_TRAP_EN
    if (k == 1) t[1:0] = 2'($urandom_range(1, 3));
`endif
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    pcSrc       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    exp_q.delete();
    acceptLog.delete();
    modelPc     = RESET_PC;
    modelHalted = 1'b0;
    memBusy     = 1'b0;
    memStale    = 1'b0;
    memDelay    = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset imem_req",    32'(imem_req),    32'd0);
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset misaligned",  32'(misaligned),  32'd0);
    check("reset state",       32'(dbgState),    32'd0);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: inputs at negedge, request checks at +1, the
  // monitor compares at +2, model updates at +3.
  task automatic tick();
    logic        rv;
    logic        ps;
    logic        accept;
    logic        expReq;
    logic [31:0] tg;
    @(negedge clk);
    rv          = memBusy && (memDelay == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? memWord(memAddr) : $urandom();
    imem_ready  = ($urandom_range(0, 99) < rdyPct);
    instr_ready = forceDrain || ($urandom_range(0, 99) < drainPct);
    ps          = forceRedir || ($urandom_range(0, 999) < redirPm);
    tg          = forceRedir ? forceTgt : randTarget();
    pcSrc       = ps;
    pcTarget    = tg;
    forceRedir  = 1'b0;
    forceDrain  = 1'b0;
    #1;
    expReq = !memBusy && (exp_q.size() < DEPTH) && !ps && !modelHalted;
    check("imem_req",    32'(imem_req),    32'(expReq));
    check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    check("misaligned",  32'(misaligned),  32'(modelHalted));
    accept = imem_req && imem_ready;
    if (accept) begin
      check("imem_addr", imem_addr, modelPc);
      acceptLog.push_back(imem_addr);
    end
    #2;
    if (ps) begin
      exp_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
      modelPc = tg;
      if (tg[1:0] != 2'b00) modelHalted = 1'b1;
`else
      modelPc = {tg[31:2], 2'b00};
`endif
      if (memBusy && !rv) memStale = 1'b1;
    end
    if (rv) begin
      if (!ps && !memStale) exp_q.push_back({memWord(memAddr), memAddr});
      memBusy  = 1'b0;
      memStale = 1'b0;
    end else if (memBusy) begin
      memDelay--;
    end
    if (accept) begin
      memBusy  = 1'b1;
      memStale = 1'b0;
      memAddr  = modelPc;
      memDelay = int'($urandom_range(minDelay, maxDelay));
      modelPc  = modelPc + 32'd4;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares the head against the scoreboard on every handover
  // ---------------------------------------------------------------------------
  logic [63:0] monEntry;
  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid && instr_ready && !pcSrc) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pop: got pc %h with nothing expected at %0t", pc, $time);
      end else begin
        monEntry = exp_q.pop_front();
        check("instr",   instr,      monEntry[63:32]);
        check("pc",      pc,         monEntry[31:0]);
        check("pcPlus4", pcPlus4,    monEntry[31:0] + 32'd4);
        check("op",      32'(op),    monEntry[63:32] & 32'h7F);
        check("f3",      32'(f3),    (monEntry[63:32] >> 12) & 32'h7);
        check("f7",      32'(f7),    monEntry[63:32] >> 25);
        if (monEntry[31:0] == RESET_PC) begin
          check("sub op", 32'(op), 32'h33);
          check("sub f3", 32'(f3), 32'h0);
          check("sub f7", 32'(f7), 32'h20);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int   logIdx;
  int   acc0;
  logic found;

  initial begin
    // In-order fetch from reset, everything always ready.
    do_reset();
    rdyPct = 100; drainPct = 100; minDelay = 0; maxDelay = 0; redirPm = 0;
    repeat (12) tick();
    if (acceptLog.size() >= 3) begin
      check("first addr",  acceptLog[0], 32'h100);
      check("second addr", acceptLog[1], 32'h104);
      check("third addr",  acceptLog[2], 32'h108);
    end else begin
      check("accept count", 32'(acceptLog.size()), 32'd3);
    end

    // Downstream stalled: exactly DEPTH requests, then drain in order.
    do_reset();
    drainPct = 0;
    repeat (10) tick();
    check("stalled requests", 32'(acceptLog.size()), 32'(DEPTH));
    drainPct = 100;
    repeat (10) tick();

    // Redirect while waiting for 0x108, stale response two cycles later.
    do_reset();
    minDelay = 2; maxDelay = 2;
    found = 1'b0;
    logIdx = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (memBusy && !memStale && memAddr == 32'h108 && memDelay != 0) begin
        forceRedir = 1'b1;
        forceTgt   = 32'h200;
        found      = 1'b1;
        logIdx     = acceptLog.size();
      end
      tick();
    end
    check("wait-redirect reached", 32'(found), 32'd1);
    if (found) begin
      @(posedge clk);
      #1;
      check("drop state", 32'(dbgState), 32'd2);
      repeat (12) tick();
      if (acceptLog.size() > logIdx) check("addr after drop", acceptLog[logIdx], 32'h200);
      else check("accepts after drop", 32'(acceptLog.size()), 32'(logIdx + 1));
    end

    // Redirect coincident with a response and a pop.
    do_reset();
    minDelay = 0; maxDelay = 0; drainPct = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_q.size() > 0 && memBusy && memDelay == 0 && !memStale) begin
        forceRedir = 1'b1;
        forceDrain = 1'b1;
        forceTgt   = 32'h300;
        found      = 1'b1;
      end
      tick();
    end
    check("coincident redirect reached", 32'(found), 32'd1);
    drainPct = 100;
    logIdx = acceptLog.size();
    tick();
    if (acceptLog.size() > logIdx) check("addr after flush", acceptLog[logIdx], 32'h300);
    else check("accepts after flush", 32'(acceptLog.size()), 32'(logIdx + 1));
    repeat (8) tick();

    // Misaligned redirect.
    do_reset();
    repeat (3) tick();
    forceRedir = 1'b1;
    forceTgt   = 32'h202;
    tick();
    logIdx = acceptLog.size();
    repeat (20) tick();
`ifdef IF_MISALIGN_TRAP_EN
    check("halted accepts", 32'(acceptLog.size()), 32'(logIdx));
    check("misaligned set", 32'(misaligned), 32'd1);
`else
    if (acceptLog.size() > logIdx) check("aligned target", acceptLog[logIdx], 32'h200);
    else check("accepts after misaligned", 32'(acceptLog.size()), 32'(logIdx + 1));
`endif

    // Randomized segments, each starting from reset.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      rdyPct   = int'($urandom_range(40, 100));
      drainPct = int'($urandom_range(30, 100));
      minDelay = 0;
      maxDelay = int'($urandom_range(0, 3));
      redirPm  = int'($urandom_range(10, 60));
      acc0     = acceptLog.size();
      repeat (800) tick();
      check("random progress", 32'(acceptLog.size() > acc0), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
